// File: rtl/clk_div_gen2.sv
// clk_div_gen2: glitch-free integer clock divider with shadowed ratio updates,
// optional 50% duty for odd ratios and a reference-domain period tick.
module clk_div_gen2 #(
  parameter int RATIO_W    = 8,
  parameter bit ODD_DUTY50 = 1'b1
) (
  input  logic               i_ref_clk,
  input  logic               i_rst_n,
  input  logic               i_clk_en,
  input  logic [RATIO_W-1:0] i_div_ratio,
  input  logic               i_ratio_load,
  output logic               o_div_clk,
  output logic               o_div_tick,
  output logic               o_ratio_ack,
  output logic [RATIO_W-1:0] o_cur_ratio
);
  typedef enum logic {BYPASS, DIVIDE} state_t;
  state_t r_state, w_state_nx;
  logic [RATIO_W-1:0] r_pend_ratio, r_cur_ratio, r_cnt, w_ratio_nx, w_cnt_nx;
  logic r_pend_valid, r_cur_en, r_a, r_b, r_tick, r_ack, w_bnd, w_en_nx, w_odd50;
  always_comb begin
    w_bnd      = (r_state == BYPASS) || (r_cnt == r_cur_ratio - RATIO_W'(1));
    w_ratio_nx = (w_bnd && r_pend_valid) ? r_pend_ratio : r_cur_ratio;
    w_en_nx    = w_bnd ? i_clk_en : r_cur_en;
    w_state_nx = !w_bnd ? r_state : (w_en_nx && w_ratio_nx >= RATIO_W'(2)) ? DIVIDE : BYPASS;
    w_cnt_nx   = w_bnd ? '0 : r_cnt + RATIO_W'(1);
  end
  // Phase and tick are computed from next-state values so both outputs are pure flops.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= BYPASS;
      r_cur_ratio  <= '0;
      r_cur_en     <= 1'b0;
      r_cnt        <= '0;
      r_pend_ratio <= '0;
      r_pend_valid <= 1'b0;
      r_ack        <= 1'b0;
      r_tick       <= 1'b0;
      r_a          <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cur_ratio  <= w_ratio_nx;
      r_cur_en     <= w_en_nx;
      r_cnt        <= w_cnt_nx;
      r_pend_ratio <= i_ratio_load ? i_div_ratio : r_pend_ratio;
      r_pend_valid <= i_ratio_load || (r_pend_valid && !w_bnd);
      r_ack        <= w_bnd && r_pend_valid;
      r_tick       <= (w_state_nx == BYPASS) || (w_cnt_nx == '0);
      r_a          <= (w_state_nx == DIVIDE) && (w_cnt_nx < (w_ratio_nx >> 1));
    end
  end
  always_ff @(negedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_b <= 1'b0;
    else r_b <= r_a;
  end
  // Mode select only changes at a boundary, where a and b are both low before the edge.
  assign w_odd50     = ODD_DUTY50 && r_cur_ratio[0];
  assign o_div_clk   = (r_state == BYPASS) ? i_ref_clk : (w_odd50 ? (r_a | r_b) : r_a);
  assign o_div_tick  = r_tick;
  assign o_ratio_ack = r_ack;
  assign o_cur_ratio = r_cur_ratio;
endmodule

// File: doc/clk_div_gen2.md
# clk_div_gen2

Parametrised, glitch-free integer clock divider for the UART system clock tree. It is the successor to the current single-mode divider. It derives a divided clock from i_ref_clk with these additions:
- configurable ratio width;
- ratio changes that are shadowed and applied only at a period boundary;
- optional true 50 % duty cycle for odd ratios;
- a reference-domain period tick and a status/acknowledge interface for the register block.

## Interface
- RATIO_W, 8, width of the division ratio; ratios 2 to 2^RATIO_W-1 divide.
- ODD_DUTY50, 1, odd ratios produce 50 % duty using a falling-edge flop when 1; when 0, high time is floor(R/2) cycles.
- i_ref_clk  in  1  reference clock; all state is clocked on its rising edge, except the duty flop, which uses the falling edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_clk_en  in  1  divider enable; sampled only at period boundaries.
- i_div_ratio  in  RATIO_W  requested ratio; sampled when i_ratio_load=1.
- i_ratio_load  in  1  single-cycle strobe that captures i_div_ratio into the pending register.
- o_div_clk  out  1  divided clock, or i_ref_clk when in bypass.
- o_div_tick  out  1  one-i_ref_clk-cycle pulse marking each divided-period start; constant 1 in bypass.
- o_ratio_ack  out  1  one-cycle pulse when a pending ratio becomes active.
- o_cur_ratio  out  RATIO_W  currently active ratio.

## Operation
- Registers:
  - pend_ratio, pend_valid: the pending request.
  - cur_ratio, cur_en: the active settings.
  - cnt (RATIO_W bits).
  - phase flop a (rising edge) and duty flop b (falling edge; its input is a).
- State machine, two states:
  - BYPASS: o_div_clk = i_ref_clk; every rising edge is a boundary.
  - DIVIDE: cnt runs 0..cur_ratio-1 and wraps; the boundary is the edge where cnt wraps to 0.
- At each boundary:
  - If pend_valid: cur_ratio <= pend_ratio, pend_valid <= 0, o_ratio_ack pulses in the following cycle.
  - cur_en <= i_clk_en.
  - Next state is DIVIDE if cur_en && cur_ratio >= 2, else BYPASS. Both use the values being loaded at this edge.
- Load strobe while a request is pending: the new value overwrites pend_ratio. Only one ack is issued, for the value finally applied.
- Load and boundary on the same edge: the value is captured at that edge and applied at the next boundary.
- Phase generation in DIVIDE:
  - a is high during cnt < floor(R/2), otherwise low.
  - Even R, or odd R with ODD_DUTY50=0: o_div_clk = a.
  - Odd R with ODD_DUTY50=1: o_div_clk = a | b, so it is high for floor(R/2)+0.5 periods and low for the same.
- Output glitch rules:
  - o_div_clk is driven only by flops, the a|b OR, and the bypass mux. No counter decode reaches the output combinationally.
  - The mux switches only at a boundary edge, where both sources rise together. No runt pulses are allowed.
- o_div_tick is registered and high in the cycle where cnt==0.
- o_cur_ratio equals cur_ratio.
- Ratio arithmetic is unsigned RATIO_W. Ratios 0 and 1 select BYPASS.

## Timing
- Reset values (asynchronous):
  - cnt=0, a=0, b=0, cur_ratio=0, cur_en=0, pend_valid=0.
  - State BYPASS, so o_div_clk follows i_ref_clk.
  - o_div_tick=0, o_ratio_ack=0, o_cur_ratio=0.
- Load latency:
  - Load at edge k in BYPASS: applied at edge k+1, ack high in cycle k+1..k+2.
  - Load in DIVIDE: applied at the next cnt wrap. Worst case is R_old cycles.
- First divided period:
  - The rising edge of o_div_clk coincides with the boundary edge.
  - o_div_tick is high in the cycle following that edge.
- Period in DIVIDE is exactly R i_ref_clk cycles. The current period always completes before any ratio or enable change.
- Deasserting i_clk_en mid-period: the period finishes, then the block enters BYPASS.
- Asserting reset mid-period: output flops clear immediately and the block enters BYPASS. Any pending request is lost.

## Test plan
- Reset behaviour: assert reset with o_div_clk high, then release → o_div_clk tracks i_ref_clk, o_cur_ratio=0, no ack or tick glitches.
- Even ratio from bypass: i_clk_en=1, load 4 → ack one cycle later, o_cur_ratio=4, period 4 cycles, high 2 / low 2, o_div_tick every 4th cycle.
- Odd ratio, both duty modes: load 5 → with ODD_DUTY50=1, high 2.5 / low 2.5 ref periods; with ODD_DUTY50=0, high 2 / low 3.
- Mid-period ratio change: running R=6, load 3 at cnt=2 → current period stays 6 cycles, then 3-cycle periods, a single ack at the wrap. A second load of 7 before the wrap overwrites → only 7 is applied, one ack.
- Disable and degenerate ratios: drop i_clk_en at cnt=1 of R=8 → 8-cycle period completes, then bypass with no runt pulse. Load 1 or 0 → BYPASS after the boundary.
- Maximum ratio: RATIO_W=8, load 255 → period 255 cycles, high 127.5 cycles when ODD_DUTY50=1, cnt wraps 254→0 correctly.
